round_robin_arbiter_n: RTL and testbench
========================================

Name: round_robin_arbiter_n

Overview:
- N-requester round-robin arbiter, the generalisation of the team's 2-request arbiter.
- Adds a one-hot grant, a binary grant index and a grant-valid flag.
- Adds an optional HOLD (lock) mode: a multi-cycle transaction keeps its grant until `last` or until its request drops.
- Sits in front of shared resources (bus, memory port, output queue) that serve one requester per cycle.

Parameters:
- N, 4, number of requesters; legal range 2..32.
- HOLD, 0; 0 = every grant is a single-cycle transaction, 1 = the grant is locked until `last` or until the request is withdrawn.
- IDX_W, $clog2(N), width of grant_idx; derived, never overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion takes effect immediately, deassertion is synchronised externally.
- requests  input  N  request vector; bit i = requester i wants the resource.
- last  input  1  the granted requester's current cycle is its final beat; used only when HOLD=1, ignored when HOLD=0.
- grants  output  N  one-hot or zero; combinational in the same cycle as requests.
- grant_valid  output  1  equals |grants.
- grant_idx  output  IDX_W  binary index of the granted requester; 0 when grant_valid=0.

Behaviour:
- State: `ptr` [IDX_W] is the highest-priority requester for the next arbitration. Also `locked` (1 bit) and `lock_idx` [IDX_W]; both are present only when HOLD=1 and are tied to 0 otherwise.
- Reset (rst_n=0): ptr=0, locked=0. grants, grant_valid and grant_idx are forced to 0 while rst_n=0, whatever the requests.
- Arbitration is combinational with zero latency. The winner is the first set bit of `requests`, scanning ptr, ptr+1, … N-1, 0, … ptr-1 (modulo N).
- No request set: grants=0, grant_valid=0, ptr and lock state unchanged.
- Pointer update when HOLD=0: on every cycle with grant_valid=1, ptr <= (winner+1) mod N; wrap from N-1 to 0.
- N=2, HOLD=0 must reproduce the legacy sequence: requests 01 00 10 11 11 00 11 00 11 11 -> grants 01 00 10 01 10 00 01 00 10 01.
- HOLD=1 state machine, two states:
  - UNLOCKED (locked=0): arbitrate as above.
    - Winner w with last=1: ptr <= w+1, stay UNLOCKED.
    - Winner w with last=0: lock_idx <= w, go to LOCKED; ptr unchanged.
  - LOCKED (locked=1):
    - If requests[lock_idx]=1: grants = onehot(lock_idx); other requests are ignored.
    - If also last=1: ptr <= lock_idx+1 and go to UNLOCKED; the next cycle arbitrates freshly.
    - If requests[lock_idx]=0 (withdrawn without last): the lock releases combinationally. The same cycle arbitrates among the others with the scan starting at lock_idx+1. The next state follows the UNLOCKED rules for the new winner. If nothing else requests: grants=0, locked <= 0, ptr <= lock_idx+1.
- Invariants: grants is never multi-hot; a granted bit is always set in requests; no requester starves. Any continuously requesting requester is granted within N-1 transactions by others.
- Reset mid-lock: the lock is dropped immediately and ptr returns to 0.
- All ptr arithmetic is modulo N, including N not a power of two.

Decomposition:
- Package `arb_pkg`:
  - typedef `arb_state_e` {ARB_UNLOCKED, ARB_LOCKED};
  - function `rr_next_idx(idx, n)` for modulo-N increment;
  - constant `ARB_MAX_N = 32`.
- One sub-module, `round_robin_pick` (purely combinational):
  - inputs: requests[N] and start[IDX_W];
  - outputs: onehot[N], idx[IDX_W], valid;
  - implementation: double-width rotate plus priority encoder.
- The top level holds the ptr/lock registers and the lock/withdraw muxing.

Test Plan:
- N=2, HOLD=0, drive the legacy vector 01 00 10 11 11 00 11 00 11 11 -> grants 01 00 10 01 10 00 01 00 10 01; grant_idx 0 - 1 0 1 - 0 - 1 0, where "-" means 0 with grant_valid=0.
- N=4, HOLD=0, requests=1111 held for 8 cycles after reset -> grant_idx 0,1,2,3,0,1,2,3; grant_valid=1 throughout.
- N=5, HOLD=0, requests=10001, ptr at 1 after granting idx 0 -> next grant idx 4, then 0; checks non-power-of-two wrap.
- N=4, HOLD=1, requests=0011, last=0 for 3 cycles then 1 -> grants 0001 for 4 cycles, then 0010 on cycle 5.
- N=4, HOLD=1, locked on idx 2, requests change 0100->1001 without last -> same cycle grants 1000 (idx 3); lock moves to 3 if last=0.
- rst_n pulsed low while locked on idx 1 with requests=1111 -> grants=0 immediately during reset; first grant after release is idx 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the N-requester round-robin arbiter.
package arb_pkg;

    localparam int ARB_MAX_N = 32;

    typedef enum logic {
        ARB_UNLOCKED,
        ARB_LOCKED
    } arb_state_e;

    function automatic int rr_next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/round_robin_pick.sv
// Combinational round-robin picker: first set request at or after start.
module round_robin_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     requests,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    localparam logic [N-1:0] ONE = N'(1);

    logic [2*N-1:0] doubled;
    logic [2*N-1:0] shifted;
    logic [N-1:0]   rotated;
    int             off;
    int             win;

    always_comb begin
        doubled = {requests, requests};
        shifted = doubled >> start;
        rotated = shifted[N-1:0];
        valid   = 1'b0;
        off     = 0;
        for (int i = 0; i < N; i++) begin
            if (!valid && rotated[i]) begin
                valid = 1'b1;
                off   = i;
            end
        end
        // Undo the rotation, wrapping modulo N.
        win = int'(start) + off;
        if (win >= N) begin
            win = win - N;
        end
        idx    = valid ? IDX_W'(win) : '0;
        onehot = valid ? (ONE << win) : '0;
    end

endmodule

// File: rtl/round_robin_arbiter_n.sv
// N-requester round-robin arbiter with optional grant lock until last.
module round_robin_arbiter_n
    import arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int HOLD  = 0,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     requests,
    input  logic             last,
    output logic [N-1:0]     grants,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    localparam logic [N-1:0] ONE = N'(1);

    if (N < 2 || N > ARB_MAX_N) begin : g_bad_n
        $error("round_robin_arbiter_n: N out of range");
    end

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_n;
    logic [IDX_W-1:0] lock_idx;
    logic [IDX_W-1:0] lock_n;
    arb_state_e       state;
    arb_state_e       state_n;

    logic             locked;
    logic             held;
    logic             withdrawn;
    logic             sel_new;
    logic             sel_idle;
    logic [IDX_W-1:0] lock_next;
    logic [IDX_W-1:0] start;

    logic [N-1:0]     pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_next;

    assign locked    = (HOLD != 0) && (state == ARB_LOCKED);
    assign held      = locked && requests[lock_idx];
    assign withdrawn = locked && !requests[lock_idx];
    assign lock_next = IDX_W'(rr_next_idx(int'(lock_idx), N));
    assign pick_next = IDX_W'(rr_next_idx(int'(pick_idx), N));
    // A withdrawn lock hands priority to the requester after the holder.
    assign start     = withdrawn ? lock_next : ptr;
    assign sel_new   = pick_valid && !held;
    assign sel_idle  = withdrawn && !pick_valid;

    round_robin_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .requests (requests),
        .start    (start),
        .onehot   (pick_onehot),
        .idx      (pick_idx),
        .valid    (pick_valid)
    );

    always_comb begin
        grants      = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        if (rst_n) begin
            if (held) begin
                grants      = ONE << lock_idx;
                grant_idx   = lock_idx;
                grant_valid = 1'b1;
            end else begin
                grants      = pick_onehot;
                grant_idx   = pick_idx;
                grant_valid = pick_valid;
            end
        end
    end

    always_comb begin
        ptr_n   = ptr;
        lock_n  = lock_idx;
        state_n = state;
        if (HOLD == 0) begin
            lock_n  = '0;
            state_n = ARB_UNLOCKED;
            if (pick_valid) begin
                ptr_n = pick_next;
            end
        end else begin
            unique case (1'b1)
                held: begin
                    if (last) begin
                        ptr_n   = lock_next;
                        state_n = ARB_UNLOCKED;
                    end
                end
                sel_new: begin
                    if (last) begin
                        ptr_n   = pick_next;
                        state_n = ARB_UNLOCKED;
                    end else begin
                        lock_n  = pick_idx;
                        state_n = ARB_LOCKED;
                    end
                end
                sel_idle: begin
                    ptr_n   = lock_next;
                    state_n = ARB_UNLOCKED;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            lock_idx <= '0;
            state    <= ARB_UNLOCKED;
        end else begin
            ptr      <= ptr_n;
            lock_idx <= lock_n;
            state    <= state_n;
        end
    end

endmodule

// File: tb/tb_round_robin_arbiter_n.sv
// Directed scoreboard bench for round_robin_arbiter_n across four configs.
module tb_round_robin_arbiter_n;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic [1:0] r0, g0;
    logic       l0, v0;
    logic [0:0] i0;
    logic [3:0] r1, g1;
    logic       l1, v1;
    logic [1:0] i1;
    logic [4:0] r2, g2;
    logic       l2, v2;
    logic [2:0] i2;
    logic [3:0] r3, g3;
    logic       l3, v3;
    logic [1:0] i3;

    round_robin_arbiter_n #(.N(2), .HOLD(0)) u_n2 (
        .clk(clk), .rst_n(rst_n), .requests(r0), .last(l0),
        .grants(g0), .grant_valid(v0), .grant_idx(i0)
    );
    round_robin_arbiter_n #(.N(4), .HOLD(0)) u_n4 (
        .clk(clk), .rst_n(rst_n), .requests(r1), .last(l1),
        .grants(g1), .grant_valid(v1), .grant_idx(i1)
    );
    round_robin_arbiter_n #(.N(5), .HOLD(0)) u_n5 (
        .clk(clk), .rst_n(rst_n), .requests(r2), .last(l2),
        .grants(g2), .grant_valid(v2), .grant_idx(i2)
    );
    round_robin_arbiter_n #(.N(4), .HOLD(1)) u_h4 (
        .clk(clk), .rst_n(rst_n), .requests(r3), .last(l3),
        .grants(g3), .grant_valid(v3), .grant_idx(i3)
    );

    typedef struct {
        string       tag;
        int          dut;
        logic [31:0] g;
        logic [4:0]  idx;
        logic        v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic drive(input int dut, input logic [31:0] req,
                         input logic lst);
        case (dut)
            0: begin r0 = req[1:0]; l0 = lst; end
            1: begin r1 = req[3:0]; l1 = lst; end
            2: begin r2 = req[4:0]; l2 = lst; end
            default: begin r3 = req[3:0]; l3 = lst; end
        endcase
    endtask

    task automatic expect_out(input string tag, input int dut,
                              input logic [31:0] g, input int idx);
        exp_t e;
        e.tag = tag;
        e.dut = dut;
        e.g   = g;
        e.idx = 5'(idx);
        e.v   = (g != 0);
        sb.push_back(e);
    endtask

    task automatic check_cycle();
        exp_t        e;
        logic [31:0] og;
        logic [4:0]  oi;
        logic        ov;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.dut)
                0: begin og = 32'(g0); oi = 5'(i0); ov = v0; end
                1: begin og = 32'(g1); oi = 5'(i1); ov = v1; end
                2: begin og = 32'(g2); oi = 5'(i2); ov = v2; end
                default: begin og = 32'(g3); oi = 5'(i3); ov = v3; end
            endcase
            checks++;
            assert (og === e.g) else begin
                errors++;
                $error("FAIL %s grants observed %0h expected %0h",
                       e.tag, og, e.g);
            end
            checks++;
            assert (oi === e.idx) else begin
                errors++;
                $error("FAIL %s grant_idx observed %0d expected %0d",
                       e.tag, oi, e.idx);
            end
            checks++;
            assert (ov === e.v) else begin
                errors++;
                $error("FAIL %s grant_valid observed %0b expected %0b",
                       e.tag, ov, e.v);
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [1:0] leg_req [10];
    logic [1:0] leg_gnt [10];
    int         leg_idx [10];
    int         n5_idx  [4];

    initial begin
        leg_req = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11,
                    2'b00, 2'b11, 2'b00, 2'b11, 2'b11};
        leg_gnt = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b10,
                    2'b00, 2'b01, 2'b00, 2'b10, 2'b01};
        leg_idx = '{0, 0, 1, 0, 1, 0, 0, 0, 1, 0};
        n5_idx  = '{0, 4, 0, 4};

        rst_n = 1'b0;
        drive(0, 0, 1'b0);
        drive(1, 0, 1'b0);
        drive(2, 0, 1'b0);
        drive(3, 32'hF, 1'b0);

        // Outputs forced to zero during reset even with requests present.
        expect_out("reset_n2", 0, 0, 0);
        expect_out("reset_h4", 3, 0, 0);
        check_cycle();
        drive(3, 0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            drive(0, 32'(leg_req[i]), 1'b0);
            expect_out($sformatf("legacy%0d", i), 0,
                       32'(leg_gnt[i]), leg_idx[i]);
            check_cycle();
        end
        drive(0, 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            drive(1, 32'hF, 1'b0);
            expect_out($sformatf("n4_all%0d", i), 1,
                       32'h1 << (i % 4), i % 4);
            check_cycle();
        end
        drive(1, 0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            drive(2, 32'b10001, 1'b0);
            expect_out($sformatf("n5_wrap%0d", i), 2,
                       32'h1 << n5_idx[i], n5_idx[i]);
            check_cycle();
        end
        drive(2, 0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            drive(3, 32'b0011, i == 3);
            expect_out($sformatf("hold_beat%0d", i), 3, 32'b0001, 0);
            check_cycle();
        end
        drive(3, 32'b0011, 1'b1);
        expect_out("hold_after_last", 3, 32'b0010, 1);
        check_cycle();
        drive(3, 0, 1'b0);
        expect_out("hold_idle", 3, 0, 0);
        check_cycle();

        drive(3, 32'b0100, 1'b0);
        expect_out("lock_on2", 3, 32'b0100, 2);
        check_cycle();
        drive(3, 32'b1001, 1'b0);
        expect_out("withdraw_to3", 3, 32'b1000, 3);
        check_cycle();
        drive(3, 32'b1100, 1'b1);
        expect_out("lock_moved3", 3, 32'b1000, 3);
        check_cycle();
        drive(3, 32'b1011, 1'b1);
        expect_out("ptr_after3", 3, 32'b0001, 0);
        check_cycle();

        drive(3, 32'b0010, 1'b0);
        expect_out("lock_on1", 3, 32'b0010, 1);
        check_cycle();
        drive(3, 32'hF, 1'b0);
        expect_out("lock_hold1", 3, 32'b0010, 1);
        check_cycle();
        rst_n = 1'b0;
        expect_out("reset_midlock", 3, 0, 0);
        check_cycle();
        rst_n = 1'b1;
        expect_out("post_reset", 3, 32'b0001, 0);
        check_cycle();
        drive(3, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
